multdiv_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the radix-4 Booth multiplier and the iterative divider. It latches operands on a one-cycle start pulse and drives the shared iteration count bus. It samples the selected datapath's result and exception at the terminal count, then returns a registered result with a one-cycle ready strobe to the processor pipeline.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_ctrl_if.sv | 32 +++
 rtl/multdiv_ctrl_iter_counter.sv | 29 ++
 rtl/multdiv_ctrl.sv | 110 +++++++++++
 tb/tb_multdiv_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_pkg;

  localparam int CNT_W         = 6;
  localparam int MULT_DONE_CNT = 17;
  localparam int DIV_DONE_CNT  = 33;

  localparam logic [CNT_W-1:0] MULT_TERM = CNT_W'(MULT_DONE_CNT);
  localparam logic [CNT_W-1:0] DIV_TERM  = CNT_W'(DIV_DONE_CNT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Bundle of processor-side start/operand/result signals and datapath-side
// operand/count/result signals around the multiply/divide controller.
interface multdiv_ctrl_if;

  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] count;
  logic [31:0] mult_product;
  logic        mult_overflow;
  logic [31:0] div_quotient;
  logic        div_exception;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  mult_product, mult_overflow, div_quotient, div_exception,
    output op_a, op_b, count, data_result, data_exception, data_resultRDY
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output mult_product, mult_overflow, div_quotient, div_exception,
    input  op_a, op_b, count, data_result, data_exception, data_resultRDY
  );

endinterface

// File: rtl/multdiv_ctrl_iter_counter.sv
// Iteration counter with synchronous clear/enable and a terminal-count flag.
module iter_counter
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_atTerm
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt    = r_cnt;
  assign o_atTerm = (r_cnt == i_term);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the Booth multiplier and iterative divider: latches operands,
// drives the shared count bus and returns the captured result with a ready strobe.
module multdiv_ctrl
  import multdiv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multdiv_ctrl_if.slave      bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_opA;
  logic [31:0]      r_opB;
  logic [31:0]      r_result;
  logic             r_exception;

  logic             w_startMult;
  logic             w_startDiv;
  logic             w_start;
  logic             w_divZero;
  logic             w_running;
  logic             w_capMult;
  logic             w_capDiv;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_term;
  logic             w_atTerm;

  // Multiply has priority when both start pulses arrive together.
  assign w_startMult = bus.ctrl_MULT;
  assign w_startDiv  = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign w_start     = w_startMult | w_startDiv;
  assign w_divZero   = w_startDiv & (bus.data_operandB == 32'd0);
  assign w_running   = (r_state == MULT_RUN) || (r_state == DIV_RUN);
  assign w_term      = (r_state == DIV_RUN) ? DIV_TERM : MULT_TERM;

  iter_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_start | ~w_running),
    .i_enable (w_running),
    .i_term   (w_term),
    .o_cnt    (w_cnt),
    .o_atTerm (w_atTerm)
  );

  always_comb begin
    w_nextState = r_state;
    w_capMult   = 1'b0;
    w_capDiv    = 1'b0;
    if (w_startMult) begin
      w_nextState = MULT_RUN;
    end else if (w_startDiv) begin
      w_nextState = w_divZero ? DONE : DIV_RUN;
    end else begin
      case (r_state)
        IDLE: w_nextState = IDLE;
        MULT_RUN: begin
          if (w_atTerm) begin
            w_capMult   = 1'b1;
            w_nextState = DONE;
          end
        end
        DIV_RUN: begin
          if (w_atTerm) begin
            w_capDiv    = 1'b1;
            w_nextState = DONE;
          end
        end
        DONE: w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_opA       <= '0;
      r_opB       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_start) begin
        r_opA <= bus.data_operandA;
        r_opB <= bus.data_operandB;
      end
      // Result registers only change on a completion, never on a plain start.
      if (w_divZero) begin
        r_result    <= '0;
        r_exception <= 1'b1;
      end else if (w_capMult) begin
        r_result    <= bus.mult_product;
        r_exception <= bus.mult_overflow;
      end else if (w_capDiv) begin
        r_result    <= bus.div_quotient;
        r_exception <= bus.div_exception;
      end
    end
  end

  assign bus.op_a           = r_opA;
  assign bus.op_b           = r_opB;
  assign bus.count          = w_running ? {{(32-CNT_W){1'b0}}, w_cnt} : 32'd0;
  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = (r_state == DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: emulated datapaths, a timing/result
// reference model, directed scenarios and a randomized start/abort/reset mix.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multdiv_ctrl_if bus ();

  multdiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [32:0] multRef(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = p[31:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  function automatic logic [32:0] divRef(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'($signed(a) / $signed(b))};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Datapaths only present a valid answer during their terminal count.
  logic [31:0] junkA = 32'h0;
  logic [31:0] junkB = 32'h0;
  logic [32:0] mulOut;
  logic [32:0] divOut;
  initial forever begin
    @(negedge clk);
    junkA = $urandom;
    junkB = $urandom;
  end
  always_comb begin
    mulOut = multRef(bus.op_a, bus.op_b);
    divOut = divRef(bus.op_a, bus.op_b);
  end
  assign bus.mult_product  = (bus.count == MULT_DONE_CNT) ? mulOut[31:0] : junkA;
  assign bus.mult_overflow = (bus.count == MULT_DONE_CNT) ? mulOut[32]   : junkB[0];
  assign bus.div_quotient  = (bus.count == DIV_DONE_CNT)  ? divOut[31:0] : junkB;
  assign bus.div_exception = (bus.count == DIV_DONE_CNT)  ? divOut[32]   : junkA[0];

  // Reference model: expected completion edge, result and held operands.
  int          edgeNo    = 0;
  int          startEdge = 0;
  int          dueEdge   = 0;
  bit          pending   = 1'b0;
  logic [31:0] pendRes   = 32'd0;
  logic        pendExc   = 1'b0;
  logic [31:0] expRes    = 32'd0;
  logic        expExc    = 1'b0;
  logic        expRdy    = 1'b0;
  logic [31:0] expA      = 32'd0;
  logic [31:0] expB      = 32'd0;

  initial forever begin
    @(posedge clk);
    edgeNo++;
    expRdy = 1'b0;
    if (reset) begin
      pending = 1'b0;
      expRes  = 32'd0;
      expExc  = 1'b0;
      expA    = 32'd0;
      expB    = 32'd0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      expA      = bus.data_operandA;
      expB      = bus.data_operandB;
      startEdge = edgeNo;
      if (bus.ctrl_MULT) begin
        {pendExc, pendRes} = multRef(expA, expB);
        dueEdge = edgeNo + MULT_DONE_CNT + 1;
        pending = 1'b1;
      end else if (expB == 32'd0) begin
        pending = 1'b0;
        expRes  = 32'd0;
        expExc  = 1'b1;
        expRdy  = 1'b1;
      end else begin
        {pendExc, pendRes} = divRef(expA, expB);
        dueEdge = edgeNo + DIV_DONE_CNT + 1;
        pending = 1'b1;
      end
    end else if (pending && edgeNo == dueEdge) begin
      expRes  = pendRes;
      expExc  = pendExc;
      expRdy  = 1'b1;
      pending = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (edgeNo > 0) begin
      checkOutput("rdy",    {31'd0, bus.data_resultRDY}, {31'd0, expRdy});
      checkOutput("count",  bus.count, pending ? 32'(edgeNo - startEdge) : 32'd0);
      checkOutput("result", bus.data_result, expRes);
      checkOutput("exc",    {31'd0, bus.data_exception}, {31'd0, expExc});
      checkOutput("opA",    bus.op_a, expA);
      checkOutput("opB",    bus.op_b, expB);
    end
  end

  task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic waitRdy(input int budget, output int edges, output int maxCnt);
    edges  = 0;
    maxCnt = int'(bus.count);
    while (bus.data_resultRDY !== 1'b1 && edges < budget) begin
      @(negedge clk);
      edges++;
      if (int'(bus.count) > maxCnt) maxCnt = int'(bus.count);
    end
  endtask

  int edges;
  int maxCnt;

  initial begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    waitRdy(40, edges, maxCnt);
    checkOutput("mulLat", edges, 32'd18);
    checkOutput("mulRes", bus.data_result, 32'hFFFF_FFEB);
    checkOutput("mulExc", {31'd0, bus.data_exception}, 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
    waitRdy(40, edges, maxCnt);
    checkOutput("ovfRes", bus.data_result, 32'hFFFF_FFFE);
    checkOutput("ovfExc", {31'd0, bus.data_exception}, 32'd1);
    checkOutput("mulMaxCnt", maxCnt, 32'd17);
    checkOutput("doneCnt", bus.count, 32'd0);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    waitRdy(60, edges, maxCnt);
    checkOutput("divLat", edges, 32'd34);
    checkOutput("divRes", bus.data_result, 32'd14);
    checkOutput("divExc", {31'd0, bus.data_exception}, 32'd0);
    checkOutput("divMaxCnt", maxCnt, 32'd33);

    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0);
    waitRdy(10, edges, maxCnt);
    checkOutput("dzLat", edges, 32'd0);
    checkOutput("dzRes", bus.data_result, 32'd0);
    checkOutput("dzExc", {31'd0, bus.data_exception}, 32'd1);
    checkOutput("dzMaxCnt", maxCnt, 32'd0);
    repeat (3) @(negedge clk);

    // Restart mid-multiply: only the second operation may complete.
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    waitRdy(40, edges, maxCnt);
    checkOutput("abortLat", edges, 32'd18);
    checkOutput("abortRes", bus.data_result, 32'd12);
    repeat (3) @(negedge clk);

    applyStimulus(1'b1, 1'b1, 32'd9, 32'd5);
    waitRdy(60, edges, maxCnt);
    checkOutput("bothLat", edges, 32'd18);
    checkOutput("bothRes", bus.data_result, 32'd45);

    // Start accepted while the previous result is being presented.
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd3);
    waitRdy(40, edges, maxCnt);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd50;
    bus.data_operandB = 32'hFFFF_FFFB;
    @(negedge clk);
    bus.ctrl_DIV = 1'b0;
    checkOutput("doneHold", bus.data_result, 32'd9);
    waitRdy(60, edges, maxCnt);
    checkOutput("doneStartLat", edges, 32'd34);
    checkOutput("doneStartRes", bus.data_result, 32'hFFFF_FFF6);

    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstRes",   bus.data_result, 32'd0);
    checkOutput("rstRdy",   {31'd0, bus.data_resultRDY}, 32'd0);
    checkOutput("rstCount", bus.count, 32'd0);
    checkOutput("rstOpA",   bus.op_a, 32'd0);
    waitRdy(40, edges, maxCnt);
    checkOutput("rstNoRdy", edges, 32'd40);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
      applyStimulus(op == 2'd0 || op == 2'd2, op != 2'd0, a, b);
      repeat ($urandom_range(0, 45)) @(negedge clk);
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
